// File: rtl/vga_demo_pkg.sv
// Shared VGA demo definitions: pattern count/width used by the painter and
// the pattern scheduler state encoding.
package vga_demo_pkg;

    localparam int NUM_PATTERNS = 16;
    localparam int PAT_W        = 4;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } sched_state_t;

endpackage

// File: rtl/pattern_scheduler.sv
// Frame-synchronous pattern sequencer: dwell-based auto advance, pause/resume
// and single-step requests, all applied only at frame boundaries.
module pattern_scheduler
    import vga_demo_pkg::*;
#(
    parameter int NUM_PATTERNS = vga_demo_pkg::NUM_PATTERNS,
    parameter int PAT_W        = vga_demo_pkg::PAT_W,
    parameter int DWELL_FRAMES = 60,
    parameter int CNT_W        = 7
) (
    input  logic             clk_50,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             run_pause,
    input  logic             next_req,
    input  logic             prev_req,
    output logic [PAT_W-1:0] pattern,
    output logic             pattern_change,
    output logic             paused,
    output logic [CNT_W-1:0] dwell_count
);

    localparam logic [PAT_W-1:0] PAT_LAST   = PAT_W'(NUM_PATTERNS - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_FRAMES - 1);

    sched_state_t state_r;
    logic         pend_next_r;
    logic         pend_prev_r;
    logic         eff_next_s;
    logic         eff_prev_s;

    // Explicit compare so non-power-of-two pattern counts wrap correctly.
    function automatic logic [PAT_W-1:0] pat_inc(input logic [PAT_W-1:0] p);
        return (p == PAT_LAST) ? '0 : p + PAT_W'(1);
    endfunction

    function automatic logic [PAT_W-1:0] pat_dec(input logic [PAT_W-1:0] p);
        return (p == '0) ? PAT_LAST : p - PAT_W'(1);
    endfunction

    // Pending step including a request seen this cycle; newest wins, both cancel.
    always_comb begin
        eff_next_s = pend_next_r;
        eff_prev_s = pend_prev_r;
        if (next_req && prev_req) begin
            eff_next_s = 1'b0;
            eff_prev_s = 1'b0;
        end else if (next_req) begin
            eff_next_s = 1'b1;
            eff_prev_s = 1'b0;
        end else if (prev_req) begin
            eff_next_s = 1'b0;
            eff_prev_s = 1'b1;
        end else begin
            eff_next_s = pend_next_r;
            eff_prev_s = pend_prev_r;
        end
    end

    // Scheduler FSM with dwell counter, pending latch and registered outputs.
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_r        <= SYNC;
            pend_next_r    <= 1'b0;
            pend_prev_r    <= 1'b0;
            pattern        <= '0;
            pattern_change <= 1'b0;
            paused         <= 1'b0;
            dwell_count    <= '0;
        end else begin
            pattern_change <= 1'b0;
            case (state_r)
                SYNC: begin
                    pend_next_r <= 1'b0;
                    pend_prev_r <= 1'b0;
                    paused      <= 1'b0;
                    if (frame_tick) begin
                        state_r <= RUN;
                    end
                end
                RUN, HOLD: begin
                    if (frame_tick) begin
                        pend_next_r <= 1'b0;
                        pend_prev_r <= 1'b0;
                        if (eff_next_s) begin
                            pattern        <= pat_inc(pattern);
                            dwell_count    <= '0;
                            pattern_change <= 1'b1;
                        end else if (eff_prev_s) begin
                            pattern        <= pat_dec(pattern);
                            dwell_count    <= '0;
                            pattern_change <= 1'b1;
                        end else if (state_r == RUN && dwell_count == DWELL_LAST) begin
                            pattern        <= pat_inc(pattern);
                            dwell_count    <= '0;
                            pattern_change <= 1'b1;
                        end else if (state_r == RUN) begin
                            dwell_count <= dwell_count + CNT_W'(1);
                        end
                    end else begin
                        pend_next_r <= eff_next_s;
                        pend_prev_r <= eff_prev_s;
                    end
                    // The tick above is judged in the old state; the toggle lands after it.
                    if (run_pause) begin
                        state_r <= (state_r == RUN) ? HOLD : RUN;
                        paused  <= (state_r == RUN);
                    end
                end
                default: begin
                    state_r     <= SYNC;
                    pend_next_r <= 1'b0;
                    pend_prev_r <= 1'b0;
                    paused      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// frame-level behavioural model of the pattern scheduler.
module tb_pattern_scheduler;

    localparam int N     = 16;
    localparam int PW    = 4;
    localparam int DWELL = 4;
    localparam int CW    = 7;

    logic          clk_50 = 1'b0;
    logic          reset = 1'b1;
    logic          frame_tick = 1'b0;
    logic          run_pause = 1'b0;
    logic          next_req = 1'b0;
    logic          prev_req = 1'b0;
    logic [PW-1:0] pattern;
    logic          pattern_change;
    logic          paused;
    logic [CW-1:0] dwell_count;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;

    // Model: mode 0 = waiting for first frame, 1 = running, 2 = held.
    int m_mode = 0;
    int m_pat  = 0;
    int m_dw   = 0;
    int m_chg  = 0;
    int m_step = 0;

    pattern_scheduler #(
        .NUM_PATTERNS(N),
        .PAT_W(PW),
        .DWELL_FRAMES(DWELL),
        .CNT_W(CW)
    ) dut (
        .clk_50(clk_50),
        .reset(reset),
        .frame_tick(frame_tick),
        .run_pause(run_pause),
        .next_req(next_req),
        .prev_req(prev_req),
        .pattern(pattern),
        .pattern_change(pattern_change),
        .paused(paused),
        .dwell_count(dwell_count)
    );

    always #10 clk_50 = ~clk_50;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One active cycle with the given inputs, then returns at the following negedge.
    task automatic cyc(input logic ft, input logic rp, input logic nx, input logic pv);
        @(negedge clk_50);
        frame_tick = ft; run_pause = rp; next_req = nx; prev_req = pv;
        @(negedge clk_50);
        frame_tick = 1'b0; run_pause = 1'b0; next_req = 1'b0; prev_req = 1'b0;
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            if (pattern_change === 1'b1) pulses++;
        end
    endtask

    // Reference model advanced once per clock, then compared just after the edge.
    initial begin
        forever begin
            @(posedge clk_50);
            if (reset) begin
                m_mode = 0; m_pat = 0; m_dw = 0; m_chg = 0; m_step = 0;
            end else begin
                m_chg = 0;
                if (m_mode == 0) begin
                    m_step = 0;
                    if (frame_tick) m_mode = 1;
                end else begin
                    if (next_req && prev_req) m_step = 0;
                    else if (next_req)        m_step = 1;
                    else if (prev_req)        m_step = -1;
                    if (frame_tick) begin
                        if (m_step != 0) begin
                            m_pat = (m_pat + N + m_step) % N; m_dw = 0; m_chg = 1;
                        end else if (m_mode == 1 && m_dw == DWELL - 1) begin
                            m_pat = (m_pat + 1) % N; m_dw = 0; m_chg = 1;
                        end else if (m_mode == 1) begin
                            m_dw = m_dw + 1;
                        end
                        m_step = 0;
                    end
                    if (run_pause) m_mode = (m_mode == 1) ? 2 : 1;
                end
            end
            #1;
            chk("model_pattern", 32'(pattern), 32'(m_pat));
            chk("model_change", 32'(pattern_change), 32'(m_chg));
            chk("model_paused", 32'(paused), (m_mode == 2) ? 32'd1 : 32'd0);
            chk("model_dwell", 32'(dwell_count), 32'(m_dw));
        end
    end

    initial begin
        int gap;
        int p0;
        repeat (3) @(negedge clk_50);
        reset = 1'b0;
        chk("rst_pattern", 32'(pattern), 32'd0);
        chk("rst_change", 32'(pattern_change), 32'd0);
        chk("rst_paused", 32'(paused), 32'd0);
        chk("rst_dwell", 32'(dwell_count), 32'd0);

        // Requests in SYNC are ignored; the first tick only enters RUN.
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("sync_pattern", 32'(pattern), 32'd0);
        chk("sync_nopulse", 32'(pattern_change), 32'd0);
        ticks(3);
        chk("dwell3", 32'(dwell_count), 32'd3);
        chk("dwell3_pat", 32'(pattern), 32'd0);
        ticks(1);
        chk("adv_pattern", 32'(pattern), 32'd1);
        chk("adv_pulse", 32'(pattern_change), 32'd1);
        chk("adv_dwell", 32'(dwell_count), 32'd0);

        // Step up to 15, then 64 ticks of auto advance.
        for (int i = 0; i < 14; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("step_to15", 32'(pattern), 32'd15);
        pulses = 0;
        ticks(4);
        chk("wrap_to0", 32'(pattern), 32'd0);
        ticks(60);
        chk("wrap_pulses", 32'(pulses), 32'd16);
        chk("wrap_end", 32'(pattern), 32'd15);

        // Pause, tick while held, resume, continue from frozen dwell.
        ticks(2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("pause_flag", 32'(paused), 32'd1);
        ticks(10);
        chk("hold_pattern", 32'(pattern), 32'd15);
        chk("hold_dwell", 32'(dwell_count), 32'd2);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("resume_flag", 32'(paused), 32'd0);
        ticks(1);
        chk("resume_dwell", 32'(dwell_count), 32'd3);
        ticks(1);
        chk("resume_adv", 32'(pattern), 32'd0);

        // Steps in HOLD at pattern 0.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(1);
        chk("hold_prev_wrap", 32'(pattern), 32'd15);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(1);
        chk("hold_next_single", 32'(pattern), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        ticks(1);
        chk("cancel_pat", 32'(pattern), 32'd0);
        chk("cancel_nopulse", 32'(pattern_change), 32'd0);

        // Resume; coincident next_req with tick at dwell 3 steps once.
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(3);
        chk("pre_coinc_dwell", 32'(dwell_count), 32'd3);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("coinc_pat", 32'(pattern), 32'd1);
        chk("coinc_dwell", 32'(dwell_count), 32'd0);
        // run_pause with tick: tick counted in RUN, then HOLD.
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("rp_tick_dwell", 32'(dwell_count), 32'd1);
        chk("rp_tick_paused", 32'(paused), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);

        // Reach pattern 7 mid-dwell and reset asynchronously.
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        ticks(2);
        chk("pre_rst_pat", 32'(pattern), 32'd7);
        #3 reset = 1'b1;
        #1;
        chk("arst_pattern", 32'(pattern), 32'd0);
        chk("arst_dwell", 32'(dwell_count), 32'd0);
        chk("arst_paused", 32'(paused), 32'd0);
        chk("arst_change", 32'(pattern_change), 32'd0);
        @(negedge clk_50);
        @(negedge clk_50);
        reset = 1'b0;
        ticks(1);
        chk("resync_pat", 32'(pattern), 32'd0);
        chk("resync_dwell", 32'(dwell_count), 32'd0);

        // Randomized traffic, frame ticks at least 2 cycles apart.
        gap = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_50);
            if (gap >= 2 && $urandom_range(0, 3) == 0) begin
                frame_tick = 1'b1; gap = 0;
            end else begin
                frame_tick = 1'b0; gap++;
            end
            run_pause = ($urandom_range(0, 39) == 0);
            next_req  = ($urandom_range(0, 9) == 0);
            prev_req  = ($urandom_range(0, 11) == 0);
            reset     = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk_50);
        frame_tick = 1'b0; run_pause = 1'b0; next_req = 1'b0; prev_req = 1'b0; reset = 1'b0;
        p0 = m_pat;
        @(negedge clk_50);
        chk("final_model_pat", 32'(pattern), 32'(p0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_scheduler.md
# pattern_scheduler

- Frame-synchronous sequencer for the VGA demo's pattern index. It replaces the free-running pattern counter with a controller in the clk_50 domain.
- Advances the pattern after a programmable number of frames. Accepts pause/resume and next/previous step requests.
- Applies every change only at a frame boundary, so the pixel painter never changes pattern mid-frame.
- Sits between the VGA timing generator (frame_tick) and the pixel painter (pattern select).

## Interface
Parameters:
- NUM_PATTERNS, 16, number of patterns; index wraps modulo this value
- PAT_W, 4, width of the pattern index, >= clog2(NUM_PATTERNS)
- DWELL_FRAMES, 60, frames each pattern is shown in RUN (1 s at 60 Hz)
- CNT_W, 7, dwell counter width, >= clog2(DWELL_FRAMES)

Ports:
- clk_50  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high
- frame_tick  in  1  one-cycle pulse at blanking entry, synchronous to clk_50
- run_pause  in  1  one-cycle pulse; toggles RUN/HOLD
- next_req  in  1  one-cycle pulse; step forward one pattern
- prev_req  in  1  one-cycle pulse; step back one pattern
- pattern  out  PAT_W  current pattern index, registered
- pattern_change  out  1  one-cycle pulse, high in the cycle pattern takes a new value
- paused  out  1  high in HOLD
- dwell_count  out  CNT_W  frames elapsed on the current pattern

## Operation
- Reset is asynchronous, active-high; clock is clk_50.
- Reset values: pattern=0, pattern_change=0, paused=0, dwell_count=0, state=SYNC, both pending flags clear.
- States:
  - SYNC: waits for the first frame_tick, then goes to RUN with pattern unchanged and no pattern_change pulse. Step requests and run_pause are ignored in SYNC.
  - RUN: dwell counting is active.
  - HOLD: dwell_count is frozen and the pattern advances only on step requests.
- run_pause in RUN goes to HOLD; in HOLD it goes to RUN. The state updates on the next edge. paused mirrors state == HOLD.
- Step requests:
  - next_req sets pend_next and clears pend_prev. prev_req sets pend_prev and clears pend_next. The most recent request wins.
  - next_req and prev_req asserted in the same cycle: both pending flags are cleared (cancel).
  - Repeated requests before a frame_tick do not accumulate; at most one step is taken per frame.
  - A request coincident with frame_tick is applied at that frame_tick.
  - Pending flags clear on every frame_tick outside SYNC.
- On frame_tick in RUN or HOLD, priority order:
  1. Pending step: pattern ±1 with wrap (NUM_PATTERNS-1 → 0, 0 → NUM_PATTERNS-1); dwell_count=0; pattern_change=1.
  2. Otherwise, in RUN with dwell_count == DWELL_FRAMES-1: pattern+1 with wrap; dwell_count=0; pattern_change=1.
  3. Otherwise, in RUN: dwell_count+1.
  4. Otherwise (HOLD, no pending step): nothing changes.
- Wrap uses an explicit compare against NUM_PATTERNS-1; do not rely on PAT_W overflow, so non-power-of-two counts work.
- run_pause coincident with frame_tick: the frame_tick is evaluated in the current state, then the state toggles.
- Reset mid-frame or mid-dwell returns the block to SYNC; pattern 0 is shown from the next frame.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- Step latency: pattern updates on the clock edge that samples frame_tick, at most one frame after the request.
- pattern_change is exactly one clk_50 cycle wide and coincides with the new pattern value.
- Dwell in RUN: the pattern holds for exactly DWELL_FRAMES frame_ticks after a change.
- frame_tick pulses must be at least 2 cycles apart; nominal spacing is 833,333 cycles.

## Structure
- Shared package vga_demo_pkg holds:
  - NUM_PATTERNS and PAT_W, shared with the pixel painter
  - the scheduler state encoding: SYNC=2'd0, RUN=2'd1, HOLD=2'd2
- No sub-module: the design is a single FSM plus the dwell counter and the pending latch, roughly 150 lines.

## Test plan
Directed scenarios, using DWELL_FRAMES=4 and NUM_PATTERNS=16:
- Reset, then 1 frame_tick, then 4 more → SYNC→RUN with pattern 0 and no pulse; pattern 1 with one pattern_change on the 5th tick; dwell_count resets to 0.
- 64 ticks in RUN starting from pattern 15 → wraps to 0, then follows the 0..15 sequence; exactly 16 pattern_change pulses.
- run_pause, then 10 ticks, then run_pause → paused=1 and pattern/dwell_count frozen; after resume, counting continues from the frozen dwell_count.
- In HOLD at pattern 0: prev_req, then a tick → pattern 15. next_req ×3, then a tick → pattern 0 (single step).
- next_req and prev_req in the same cycle, then a tick → no change. next_req coincident with a tick at dwell_count=3 → pattern+1 once, dwell_count=0.
- Reset asserted mid-dwell at pattern 7 → all outputs 0 immediately; SYNC is re-entered.
